// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter/sequencer for an external async 16-bit SRAM; ack after WAIT_CYCLES+3 cycles.
// Losing port simply waits with req held; every SRAM pin and ack is driven straight from a flop.
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  reset_in,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [1:0]            a_be,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic [1:0]            b_be,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dat_write,
    input  logic [DATA_WIDTH-1:0] sram_dat_read,
    output logic                  sram_dat_oe,
    output logic                  sram_cs_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state;
    logic [2:0]      wait_cnt;
    logic            owner_b;   // port granted most recently; doubles as last-served for round robin
    logic            cur_we;
    logic            grant_b;
    logic            sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]      sel_be;

    assign grant_b   = !a_req || (b_req && !owner_b);
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    assign sel_be    = grant_b ? b_be    : a_be;

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            owner_b        <= 1'b1;
            cur_we         <= 1'b0;
            sram_addr      <= '0;
            sram_dat_write <= '0;
            sram_dat_oe    <= 1'b0;
            sram_cs_n      <= 1'b1;
            sram_we_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_ub_n      <= 1'b1;
            sram_lb_n      <= 1'b1;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state     <= SETUP;
                        owner_b   <= grant_b;
                        cur_we    <= sel_we;
                        sram_addr <= sel_addr;
                        sram_cs_n <= 1'b0;
                        sram_ub_n <= !sel_be[1];
                        sram_lb_n <= !sel_be[0];
                        if (sel_we) begin
                            sram_dat_oe    <= 1'b1;
                            sram_dat_write <= sel_wdata;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    wait_cnt <= '0;
                    if (cur_we) begin
                        sram_we_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (wait_cnt == 3'(WAIT_CYCLES)) begin
                        // Capture lands in rdata at the same edge ack rises, so both appear in HOLD.
                        state     <= HOLD;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        a_ack     <= !owner_b;
                        b_ack     <= owner_b;
                        if (!cur_we) begin
                            if (owner_b) begin
                                b_rdata <= sram_dat_read;
                            end else begin
                                a_rdata <= sram_dat_read;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    state       <= IDLE;
                    sram_cs_n   <= 1'b1;
                    sram_ub_n   <= 1'b1;
                    sram_lb_n   <= 1'b1;
                    sram_dat_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
